// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - dump control, register-file A-port and word-stream bundle
// The slave side is the dump engine; the master side is the debug host plus register file.
interface regfile_dump_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 5
);
  logic                  start;
  logic [IDX_WIDTH-1:0]  first_reg;
  logic [IDX_WIDTH-1:0]  last_reg;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] checksum;
  logic [IDX_WIDTH-1:0]  ra;
  logic [DATA_WIDTH-1:0] bus_a;
  logic                  dump_valid;
  logic                  ready;
  logic [IDX_WIDTH-1:0]  dump_idx;
  logic [DATA_WIDTH-1:0] dump_data;

  modport master (
    output start, first_reg, last_reg, bus_a, ready,
    input  busy, done, error, checksum, ra, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  start, first_reg, last_reg, bus_a, ready,
    output busy, done, error, checksum, ra, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range over the A read port and streams it out
// RA is owned by this block only while busy; each word is snapshotted on its READ edge.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  regfile_dump_reader_if.slave rf_if
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FINISH} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_WIDTH-1:0]  r_ra;
  logic [IDX_WIDTH-1:0]  w_ra_next;
  logic [IDX_WIDTH-1:0]  r_last;
  logic [IDX_WIDTH-1:0]  w_last_next;
  logic [IDX_WIDTH-1:0]  r_dump_idx;
  logic [IDX_WIDTH-1:0]  w_dump_idx_next;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic [DATA_WIDTH-1:0] w_dump_data_next;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic [DATA_WIDTH-1:0] w_checksum_next;
  logic                  r_dump_valid;
  logic                  w_dump_valid_next;
  logic                  r_error;
  logic                  w_error_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_ra         <= '0;
      r_last       <= '0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
      r_checksum   <= '0;
      r_dump_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ra         <= w_ra_next;
      r_last       <= w_last_next;
      r_dump_idx   <= w_dump_idx_next;
      r_dump_data  <= w_dump_data_next;
      r_checksum   <= w_checksum_next;
      r_dump_valid <= w_dump_valid_next;
      r_error      <= w_error_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ra_next         = r_ra;
    w_last_next       = r_last;
    w_dump_idx_next   = r_dump_idx;
    w_dump_data_next  = r_dump_data;
    w_checksum_next   = r_checksum;
    w_dump_valid_next = r_dump_valid;
    w_error_next      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rf_if.start) begin
          if (rf_if.first_reg <= rf_if.last_reg) begin
            w_ra_next       = rf_if.first_reg;
            w_last_next     = rf_if.last_reg;
            w_checksum_next = '0;
            w_state_next    = READ;
          end else begin
            w_error_next = 1'b1;
          end
        end
      end
      READ: begin
        w_dump_data_next  = rf_if.bus_a;
        w_dump_idx_next   = r_ra;
        w_dump_valid_next = 1'b1;
        w_state_next      = HOLD;
      end
      HOLD: begin
        if (rf_if.ready) begin
          w_dump_valid_next = 1'b0;
          w_checksum_next   = r_checksum ^ r_dump_data;
          // Stopping on the last index before incrementing keeps RA from wrapping at 31.
          if (r_dump_idx == r_last) begin
            w_state_next = FINISH;
          end else begin
            w_ra_next    = r_ra + 1'b1;
            w_state_next = READ;
          end
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign rf_if.ra         = r_ra;
  assign rf_if.busy       = (r_state != IDLE);
  assign rf_if.done       = (r_state == FINISH);
  assign rf_if.error      = r_error;
  assign rf_if.checksum   = r_checksum;
  assign rf_if.dump_valid = r_dump_valid;
  assign rf_if.dump_idx   = r_dump_idx;
  assign rf_if.dump_data  = r_dump_data;

endmodule
